// File: rtl/lu_pkg.sv
// Shared types for the lu matrix scheduler: complex element, row and sequencer states.
package lu_pkg;
    localparam int LU_SIZE  = 4;
    localparam int LU_WIDTH = 64;

    typedef struct packed {
        logic [LU_WIDTH-1:0] imag;
        logic [LU_WIDTH-1:0] real_part;
    } cplx_t;

    typedef cplx_t [LU_SIZE-1:0] row_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_BUSY,
        RUN,
        UNLOAD
    } sched_state_e;
endpackage

// File: rtl/lu_row_buf.sv
// SIZE-row flop buffer: one registered read port (read-before-write), one write port,
// and a combinational read for host unload.
module lu_row_buf #(
    parameter int SIZE  = 4,
    parameter int WIDTH = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rd_en,
    input  logic [$clog2(SIZE)-1:0]     rd_addr,
    output logic [SIZE*2*WIDTH-1:0]     rd_row,
    input  logic                        wr_en,
    input  logic [$clog2(SIZE)-1:0]     wr_addr,
    input  logic [SIZE*2*WIDTH-1:0]     wr_row,
    input  logic [$clog2(SIZE)-1:0]     host_addr,
    output logic [SIZE*2*WIDTH-1:0]     host_row
);
    localparam int RW = SIZE*2*WIDTH;

    logic [RW-1:0] mem [SIZE];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_row;
        end
    end

    // Sampling the old array content at the same edge as a write gives read-before-write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_row <= '0;
        end else if (rd_en) begin
            rd_row <= mem[rd_addr];
        end
    end

    assign host_row = mem[host_addr];
endmodule

// File: rtl/lu_mat_sched.sv
// Sequencer for the lu engine: loads a matrix from the host, starts lu, serves its
// row port from the internal buffer, then streams the factored rows back out.
module lu_mat_sched
    import lu_pkg::*;
#(
    parameter int SIZE  = LU_SIZE,
    parameter int WIDTH = LU_WIDTH
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,
    input  logic [SIZE*2*WIDTH-1:0]     host_in_row_i,
    input  logic                        host_in_valid_i,
    output logic                        host_in_ready_o,
    output logic [SIZE*2*WIDTH-1:0]     host_out_row_o,
    output logic [$clog2(SIZE)-1:0]     host_out_addr_o,
    output logic                        host_out_valid_o,
    input  logic                        host_out_ready_i,
    output logic                        lu_start_o,
    input  logic                        lu_busy_i,
    input  logic [$clog2(SIZE)-1:0]     lu_rd_addr_i,
    input  logic                        lu_rd_valid_i,
    output logic [SIZE*2*WIDTH-1:0]     lu_row_o,
    output logic [$clog2(SIZE)-1:0]     lu_row_addr_o,
    output logic                        lu_row_valid_o,
    input  logic [SIZE*2*WIDTH-1:0]     lu_wr_row_i,
    input  logic [$clog2(SIZE)-1:0]     lu_wr_addr_i,
    input  logic                        lu_wr_valid_i,
    output logic                        lu_wr_ready_o,
    output logic                        busy_o,
    output logic                        done_o
);
    localparam int AW = $clog2(SIZE);
    localparam int RW = SIZE*2*WIDTH;
    localparam logic [AW-1:0] LAST = AW'(SIZE-1);

    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_LOAD   = LOAD;
    localparam logic [2:0] ST_START  = START;
    localparam logic [2:0] ST_WAIT   = WAIT_BUSY;
    localparam logic [2:0] ST_RUN    = RUN;
    localparam logic [2:0] ST_UNLOAD = UNLOAD;

    logic [2:0]    state_reg, state_next;
    logic [AW-1:0] cnt_reg, cnt_next;
    logic          done_reg, done_next;
    logic          row_valid_reg;
    logic [AW-1:0] row_addr_reg;
    logic          serving, host_in_fire, rd_en, wr_en;
    logic [AW-1:0] wr_addr;
    logic [RW-1:0] wr_row, host_row;

    assign serving      = (state_reg == ST_WAIT) || (state_reg == ST_RUN);
    // Ready is held low while reset is asserted so every output reads 0 during reset.
    assign host_in_ready_o = rst_ni && ((state_reg == ST_IDLE) || (state_reg == ST_LOAD));
    assign host_in_fire = host_in_valid_i && host_in_ready_o;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        done_next  = 1'b0;
        case (state_reg)
            ST_IDLE: if (host_in_fire) begin
                cnt_next   = AW'(1);
                state_next = ST_LOAD;
            end
            ST_LOAD: if (host_in_fire) begin
                cnt_next = cnt_reg + AW'(1);
                if (cnt_reg == LAST) begin
                    cnt_next   = '0;
                    state_next = ST_START;
                end
            end
            ST_START: state_next = ST_WAIT;
            ST_WAIT:  if (lu_busy_i) state_next = ST_RUN;
            ST_RUN: if (!lu_busy_i) begin
                cnt_next   = '0;
                state_next = ST_UNLOAD;
            end
            ST_UNLOAD: if (host_out_ready_i) begin
                cnt_next = cnt_reg + AW'(1);
                if (cnt_reg == LAST) begin
                    cnt_next   = '0;
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (flush_i) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
            done_next  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            done_reg      <= 1'b0;
            row_valid_reg <= 1'b0;
            row_addr_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            done_reg      <= done_next;
            row_valid_reg <= rd_en;
            if (rd_en) begin
                row_addr_reg <= lu_rd_addr_i;
            end
        end
    end

    // Host loads and lu write-backs never overlap: they belong to disjoint states.
    assign rd_en   = !flush_i && serving && lu_rd_valid_i;
    assign wr_en   = !flush_i && (host_in_fire || (serving && lu_wr_valid_i));
    assign wr_addr = serving ? lu_wr_addr_i : cnt_reg;
    assign wr_row  = serving ? lu_wr_row_i  : host_in_row_i;

    lu_row_buf #(
        .SIZE  (SIZE),
        .WIDTH (WIDTH)
    ) u_row_buf (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .rd_en     (rd_en),
        .rd_addr   (lu_rd_addr_i),
        .rd_row    (lu_row_o),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_row    (wr_row),
        .host_addr (cnt_reg),
        .host_row  (host_row)
    );

    assign host_out_valid_o = (state_reg == ST_UNLOAD);
    assign host_out_row_o   = host_out_valid_o ? host_row : '0;
    assign host_out_addr_o  = host_out_valid_o ? cnt_reg  : '0;
    assign lu_start_o       = (state_reg == ST_START);
    assign lu_row_addr_o    = row_addr_reg;
    assign lu_row_valid_o   = row_valid_reg;
    assign lu_wr_ready_o    = serving;
    assign busy_o           = (state_reg != ST_IDLE);
    assign done_o           = done_reg;
endmodule

// File: tb/tb_lu_mat_sched.sv
// Bench for lu_mat_sched: scenario tasks checked against an array model of the matrix.
module tb_lu_mat_sched;
    localparam int SIZE  = 4;
    localparam int WIDTH = 64;
    localparam int AW    = $clog2(SIZE);
    localparam int RW    = SIZE*2*WIDTH;
    localparam int EW    = 2*WIDTH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          flush = 1'b0;
    logic [RW-1:0] host_in_row = '0;
    logic          host_in_valid = 1'b0;
    logic          host_in_ready;
    logic [RW-1:0] host_out_row;
    logic [AW-1:0] host_out_addr;
    logic          host_out_valid;
    logic          host_out_ready = 1'b0;
    logic          lu_start;
    logic          lu_busy = 1'b0;
    logic [AW-1:0] lu_rd_addr = '0;
    logic          lu_rd_valid = 1'b0;
    logic [RW-1:0] lu_row;
    logic [AW-1:0] lu_row_addr;
    logic          lu_row_valid;
    logic [RW-1:0] lu_wr_row = '0;
    logic [AW-1:0] lu_wr_addr = '0;
    logic          lu_wr_valid = 1'b0;
    logic          lu_wr_ready;
    logic          busy;
    logic          done;

    int checks = 0;
    int failures = 0;
    logic [RW-1:0] model [SIZE];

    always #5 clk = ~clk;

    lu_mat_sched #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .flush_i          (flush),
        .host_in_row_i    (host_in_row),
        .host_in_valid_i  (host_in_valid),
        .host_in_ready_o  (host_in_ready),
        .host_out_row_o   (host_out_row),
        .host_out_addr_o  (host_out_addr),
        .host_out_valid_o (host_out_valid),
        .host_out_ready_i (host_out_ready),
        .lu_start_o       (lu_start),
        .lu_busy_i        (lu_busy),
        .lu_rd_addr_i     (lu_rd_addr),
        .lu_rd_valid_i    (lu_rd_valid),
        .lu_row_o         (lu_row),
        .lu_row_addr_o    (lu_row_addr),
        .lu_row_valid_o   (lu_row_valid),
        .lu_wr_row_i      (lu_wr_row),
        .lu_wr_addr_i     (lu_wr_addr),
        .lu_wr_valid_i    (lu_wr_valid),
        .lu_wr_ready_o    (lu_wr_ready),
        .busy_o           (busy),
        .done_o           (done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [EW-1:0] elem(input real re, input real im);
        return {$realtobits(im), $realtobits(re)};
    endfunction

    function automatic logic [RW-1:0] rand_row();
        logic [RW-1:0] r;
        for (int k = 0; k < RW/32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic fill_random(input bit upper);
        for (int i = 0; i < SIZE; i++) begin
            model[i] = rand_row();
            if (upper)
                for (int j = 0; j < i; j++) model[i][j*EW +: EW] = '0;
        end
    endtask

    task automatic load_matrix(input string tag);
        for (int i = 0; i < SIZE; i++) begin
            host_in_valid = 1'b1;
            host_in_row   = model[i];
            checks++;
            if (host_in_ready !== 1'b1 || lu_start !== 1'b0) begin
                failures++;
                $display("FAIL %s_load row %0d: ready=%b start=%b, required ready=1 start=0", tag, i, host_in_ready, lu_start);
            end
            step();
        end
        host_in_valid = 1'b0;
        checks++;
        if (lu_start !== 1'b1 || busy !== 1'b1 || lu_wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s_start: start=%b busy=%b wr_ready=%b, required 1 1 0", tag, lu_start, busy, lu_wr_ready);
        end
        step();
        checks++;
        if (lu_start !== 1'b0 || lu_wr_ready !== 1'b1 || host_in_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL %s_wait: start=%b wr_ready=%b in_ready=%b busy=%b, required 0 1 0 1", tag, lu_start, lu_wr_ready, host_in_ready, busy);
        end
        $display("load %s: %0d rows streamed, start pulse seen", tag, SIZE);
    endtask

    task automatic unload_check(input bit bp, input string tag);
        int idx = 0;
        int cyc = 0;
        int dones = 0;
        bit rdy;
        bit last_done = 1'b0;
        while (idx < SIZE && cyc < 100) begin
            rdy = bp ? (cyc % 2 == 1) : 1'b1;
            host_out_ready = rdy;
            checks++;
            if (host_out_valid !== 1'b1 || host_out_addr !== AW'(idx) || host_out_row !== model[idx]) begin
                failures++;
                $display("FAIL %s_row: valid=%b addr=%0d row=%h, required valid=1 addr=%0d row=%h", tag, host_out_valid, host_out_addr, host_out_row, idx, model[idx]);
            end
            step();
            cyc++;
            if (done === 1'b1) dones++;
            if (rdy) begin
                $display("unload %s: row %0d accepted", tag, idx);
                idx++;
            end
            last_done = (done === 1'b1);
        end
        host_out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (done === 1'b1) dones++;
        end
        checks++;
        if (dones != 1 || !last_done || busy !== 1'b0 || host_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_done: pulses=%0d after_last=%b busy=%b valid=%b, required 1 1 0 0", tag, dones, last_done, busy, host_out_valid);
        end
    endtask

    task automatic random_serve(input int n);
        logic [RW-1:0] exp_row;
        logic [AW-1:0] raddr;
        logic [AW-1:0] waddr;
        bit rd;
        bit wr;
        for (int k = 0; k < n; k++) begin
            rd    = 1'($urandom_range(0, 1));
            wr    = 1'($urandom_range(0, 1));
            raddr = AW'($urandom_range(0, SIZE-1));
            waddr = AW'($urandom_range(0, SIZE-1));
            lu_rd_valid   = rd;
            lu_rd_addr    = raddr;
            lu_wr_valid   = wr;
            lu_wr_addr    = waddr;
            lu_wr_row     = rand_row();
            host_in_valid = 1'($urandom_range(0, 1));
            host_in_row   = rand_row();
            exp_row = model[raddr];
            if (wr) model[waddr] = lu_wr_row;
            checks++;
            if (lu_wr_ready !== 1'b1 || host_in_ready !== 1'b0) begin
                failures++;
                $display("FAIL serve_ready: wr_ready=%b in_ready=%b, required 1 0", lu_wr_ready, host_in_ready);
            end
            step();
            checks++;
            if (rd) begin
                if (lu_row_valid !== 1'b1 || lu_row_addr !== raddr || lu_row !== exp_row) begin
                    failures++;
                    $display("FAIL serve_read: valid=%b addr=%0d row=%h, required 1 %0d %h", lu_row_valid, lu_row_addr, lu_row, raddr, exp_row);
                end
            end else if (lu_row_valid !== 1'b0) begin
                failures++;
                $display("FAIL serve_idle: valid=%b, required 0", lu_row_valid);
            end
            $display("serve: rd=%b@%0d wr=%b@%0d", rd, raddr, wr, waddr);
        end
        lu_rd_valid = 1'b0;
        lu_wr_valid = 1'b0;
        host_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({host_in_ready, host_out_valid, lu_start, lu_row_valid, lu_wr_ready, busy, done} !== 7'b0 ||
            host_out_row !== '0 || lu_row !== '0 || host_out_addr !== '0 || lu_row_addr !== '0) begin
            failures++;
            $display("FAIL reset_outputs: flags=%b addr=%0d/%0d, required all 0",
                     {host_in_ready, host_out_valid, lu_start, lu_row_valid, lu_wr_ready, busy, done}, host_out_addr, lu_row_addr);
        end
        #2 rst_n = 1'b1;
        step();
        checks++;
        if (host_in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: in_ready=%b busy=%b, required 1 0", host_in_ready, busy);
        end
        $display("reset: done");
    endtask

    task automatic test_load();
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++)
                model[i][j*EW +: EW] = elem(real'(i*4+j), -real'(i*4+j));
        load_matrix("pattern");
    endtask

    task automatic test_read_latency();
        logic [EW-1:0] want;
        want = elem(11.0, -11.0);
        lu_rd_valid = 1'b1;
        lu_rd_addr  = AW'(2);
        step();
        lu_rd_valid = 1'b0;
        checks++;
        if (lu_row_valid !== 1'b1 || lu_row_addr !== AW'(2) || lu_row[3*EW +: EW] !== want || lu_row !== model[2]) begin
            failures++;
            $display("FAIL read_latency: valid=%b addr=%0d e3=%h, required 1 2 %h", lu_row_valid, lu_row_addr, lu_row[3*EW +: EW], want);
        end
        step();
        checks++;
        if (lu_row_valid !== 1'b0) begin
            failures++;
            $display("FAIL read_drop: valid=%b, required 0", lu_row_valid);
        end
        $display("read_latency: row 2 returned");
    endtask

    task automatic test_collision();
        logic [RW-1:0] sevens;
        logic [RW-1:0] old_row;
        for (int j = 0; j < SIZE; j++) sevens[j*EW +: EW] = elem(7.0, 0.0);
        old_row = model[1];
        lu_wr_valid = 1'b1;
        lu_wr_addr  = AW'(1);
        lu_wr_row   = sevens;
        lu_rd_valid = 1'b1;
        lu_rd_addr  = AW'(1);
        model[1] = sevens;
        step();
        lu_wr_valid = 1'b0;
        checks++;
        if (lu_row_valid !== 1'b1 || lu_row !== old_row) begin
            failures++;
            $display("FAIL collision_old: valid=%b row=%h, required 1 %h", lu_row_valid, lu_row, old_row);
        end
        step();
        lu_rd_valid = 1'b0;
        checks++;
        if (lu_row_valid !== 1'b1 || lu_row !== sevens) begin
            failures++;
            $display("FAIL collision_new: valid=%b row=%h, required 1 %h", lu_row_valid, lu_row, sevens);
        end
        $display("collision: read-before-write observed");
    endtask

    task automatic test_random_run();
        lu_busy = 1'b0;
        random_serve(12);
        lu_busy = 1'b1;
        random_serve(12);
        lu_busy = 1'b0;
        step();
        unload_check(1'b1, "random_bp");
    endtask

    task automatic test_full_run();
        int pend = -1;
        fill_random(1'b1);
        load_matrix("upper");
        lu_busy = 1'b1;
        for (int k = 0; k < 20; k++) begin
            lu_wr_valid = 1'b0;
            if (pend >= 0) begin
                checks++;
                if (lu_row_valid !== 1'b1 || lu_row_addr !== AW'(pend) || lu_row !== model[pend]) begin
                    failures++;
                    $display("FAIL lu_model_read: valid=%b addr=%0d row=%h, required 1 %0d %h", lu_row_valid, lu_row_addr, lu_row, pend, model[pend]);
                end
                lu_wr_valid = 1'b1;
                lu_wr_addr  = lu_row_addr;
                lu_wr_row   = lu_row;
            end
            lu_rd_valid = (k < 16);
            lu_rd_addr  = AW'(k % SIZE);
            pend = (k < 16) ? (k % SIZE) : -1;
            step();
        end
        lu_rd_valid = 1'b0;
        lu_wr_valid = 1'b0;
        lu_busy = 1'b0;
        step();
        unload_check(1'b0, "upper");
    endtask

    task automatic test_flush();
        int dones = 0;
        fill_random(1'b0);
        load_matrix("flush");
        lu_busy = 1'b1;
        step();
        for (int k = 0; k < 2; k++) begin
            lu_wr_valid = 1'b1;
            lu_wr_addr  = AW'(k);
            lu_wr_row   = rand_row();
            step();
        end
        lu_wr_valid = 1'b0;
        flush       = 1'b1;
        lu_rd_valid = 1'b1;
        lu_rd_addr  = '0;
        step();
        flush       = 1'b0;
        lu_busy     = 1'b0;
        checks++;
        if (busy !== 1'b0 || lu_wr_ready !== 1'b0 || host_in_ready !== 1'b1 || lu_row_valid !== 1'b0 ||
            lu_start !== 1'b0 || host_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_state: busy=%b wr_ready=%b in_ready=%b row_valid=%b start=%b out_valid=%b, required 0 0 1 0 0 0",
                     busy, lu_wr_ready, host_in_ready, lu_row_valid, lu_start, host_out_valid);
        end
        step();
        lu_rd_valid = 1'b0;
        checks++;
        if (lu_row_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_read_ignored: valid=%b, required 0", lu_row_valid);
        end
        if (done === 1'b1) dones++;
        for (int k = 0; k < 4; k++) begin
            step();
            if (done === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL flush_no_done: pulses=%0d, required 0", dones);
        end
        $display("flush: back in idle");
    endtask

    task automatic test_async_reset();
        fill_random(1'b0);
        load_matrix("pre_rst");
        lu_busy = 1'b1;
        step();
        lu_busy = 1'b0;
        step();
        host_out_ready = 1'b1;
        step();
        host_out_ready = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({host_in_ready, host_out_valid, lu_start, lu_row_valid, lu_wr_ready, busy, done} !== 7'b0 ||
            host_out_row !== '0 || host_out_addr !== '0 || lu_row !== '0) begin
            failures++;
            $display("FAIL async_reset: flags=%b addr=%0d, required all 0",
                     {host_in_ready, host_out_valid, lu_start, lu_row_valid, lu_wr_ready, busy, done}, host_out_addr);
        end
        #3 rst_n = 1'b1;
        step();
        checks++;
        if (host_in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL async_release: in_ready=%b busy=%b, required 1 0", host_in_ready, busy);
        end
        $display("async_reset: applied mid-unload");
        fill_random(1'b0);
        load_matrix("post_rst");
        lu_busy = 1'b1;
        step();
        lu_busy = 1'b0;
        step();
        unload_check(1'b1, "post_rst");
    endtask

    initial begin
        test_reset();
        test_load();
        test_read_latency();
        test_collision();
        test_random_run();
        test_full_run();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end
endmodule
